// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - shared Y86-64 constants, hazard FSM state type and status helper
//
// Purpose: icode, status and register constants used by the pipeline control
// logic, the hazard-unit state enum, and is_exc() to classify status codes.
package y86_pkg;

  // Instruction codes
  localparam logic [3:0] I_HALT   = 4'd0;
  localparam logic [3:0] I_NOP    = 4'd1;
  localparam logic [3:0] I_MRMOVQ = 4'd5;
  localparam logic [3:0] I_OPQ    = 4'd6;
  localparam logic [3:0] I_JXX    = 4'd7;
  localparam logic [3:0] I_RET    = 4'd9;
  localparam logic [3:0] I_POPQ   = 4'd11;

  // Status codes
  localparam logic [3:0] S_AOK = 4'd1;
  localparam logic [3:0] S_HLT = 4'd2;
  localparam logic [3:0] S_ADR = 4'd3;
  localparam logic [3:0] S_INS = 4'd4;

  // "No register" identifier
  localparam logic [3:0] RNONE = 4'd15;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_HALTED   = 2'd2
  } hcu_state_t;

  function automatic logic is_exc(input logic [3:0] stat);
    return (stat == S_HLT) || (stat == S_ADR) || (stat == S_INS);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating event counter with synchronous clear
//
// Purpose: counts cycles where inc is high, sticking at all-ones; clr wins
// over inc in the same cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   inc         count this cycle
//   clr         synchronous clear
//   count       current value (CNT_W bits)
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// rtl/hazard_ctrl_unit.sv - Y86-64 pipeline stall/bubble control with memory-wait FSM
//
// Purpose: combinational stall/bubble/set_cc generation for the F/D/E/M/W
// pipeline registers, a RUN/MEM_WAIT/HALTED state machine with a memory-wait
// timeout, and four saturating performance counters.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   D_icode, E_icode, M_icode       stage instruction codes
//   e_cnd                           branch condition from E
//   E_dstM                          load destination in E
//   d_srcA, d_srcB                  decode source registers
//   m_stat, W_stat                  memory-stage / writeback status
//   mem_req, mem_ready              data-memory handshake
//   cnt_clr                         synchronous counter clear
//   *_stall, *_bubble, set_cc       pipeline register controls
//   state                           FSM state (RUN=0, MEM_WAIT=1, HALTED=2)
//   mem_timeout                     sticky: halt was caused by a memory timeout
//   cnt_*                           event counters
module hazard_ctrl_unit
  import y86_pkg::*;
#(
  parameter int ICODE_W     = 4,
  parameter int REG_W       = 4,
  parameter int STAT_W      = 4,
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ICODE_W-1:0] D_icode,
  input  logic [ICODE_W-1:0] E_icode,
  input  logic [ICODE_W-1:0] M_icode,
  input  logic               e_cnd,
  input  logic [REG_W-1:0]   E_dstM,
  input  logic [REG_W-1:0]   d_srcA,
  input  logic [REG_W-1:0]   d_srcB,
  input  logic [STAT_W-1:0]  m_stat,
  input  logic [STAT_W-1:0]  W_stat,
  input  logic               mem_req,
  input  logic               mem_ready,
  input  logic               cnt_clr,
  output logic               F_stall,
  output logic               D_stall,
  output logic               E_stall,
  output logic               M_stall,
  output logic               W_stall,
  output logic               D_bubble,
  output logic               E_bubble,
  output logic               M_bubble,
  output logic               W_bubble,
  output logic               set_cc,
  output logic [1:0]         state,
  output logic               mem_timeout,
  output logic [CNT_W-1:0]   cnt_load_use,
  output logic [CNT_W-1:0]   cnt_mispredict,
  output logic [CNT_W-1:0]   cnt_ret,
  output logic [CNT_W-1:0]   cnt_mem_wait
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hcu_state_t        st;
  logic [WAIT_W-1:0] wait_cnt;

  logic load_use, mispredict, ret_p, exc_m, exc_w, mem_wait, halted;

  // Hazard terms. RNONE destinations never create a load-use dependency.
  assign load_use   = ((E_icode == ICODE_W'(I_MRMOVQ)) || (E_icode == ICODE_W'(I_POPQ)))
                      && (E_dstM != REG_W'(RNONE))
                      && ((E_dstM == d_srcA) || (E_dstM == d_srcB));
  assign mispredict = (E_icode == ICODE_W'(I_JXX)) && !e_cnd;
  assign ret_p      = (D_icode == ICODE_W'(I_RET)) || (E_icode == ICODE_W'(I_RET))
                      || (M_icode == ICODE_W'(I_RET));
  assign exc_m      = is_exc(4'(m_stat));
  assign exc_w      = is_exc(4'(W_stat));
  assign mem_wait   = mem_req && !mem_ready;
  assign halted     = (st == ST_HALTED);

  // Pipeline controls. HALTED freezes everything; a pending memory access
  // freezes F..M and drains W; otherwise normal hazard resolution applies.
  always_comb begin
    F_stall  = 1'b0;
    D_stall  = 1'b0;
    E_stall  = 1'b0;
    M_stall  = 1'b0;
    W_stall  = 1'b0;
    D_bubble = 1'b0;
    E_bubble = 1'b0;
    M_bubble = 1'b0;
    W_bubble = 1'b0;
    set_cc   = 1'b0;
    if (!rst_n) begin
      D_bubble = 1'b1;
      E_bubble = 1'b1;
      M_bubble = 1'b1;
    end else if (halted) begin
      F_stall = 1'b1;
      D_stall = 1'b1;
      E_stall = 1'b1;
      M_stall = 1'b1;
      W_stall = 1'b1;
    end else if (mem_wait) begin
      F_stall  = 1'b1;
      D_stall  = 1'b1;
      E_stall  = 1'b1;
      M_stall  = 1'b1;
      W_bubble = !exc_w;
      W_stall  = exc_w;
    end else begin
      F_stall  = load_use || ret_p;
      D_stall  = load_use;
      D_bubble = mispredict || (!load_use && ret_p);
      E_bubble = mispredict || load_use;
      M_bubble = exc_m || exc_w;
      W_stall  = exc_w;
      set_cc   = (E_icode == ICODE_W'(I_OPQ)) && !exc_m && !exc_w;
    end
  end

  // wait_cnt holds the number of wait cycles already completed before the
  // current one, so the compare fires during wait cycle MEM_TIMEOUT+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st          <= ST_RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
    end else if (exc_w) begin
      st <= ST_HALTED;
    end else begin
      case (st)
        ST_RUN: begin
          if (mem_wait) begin
            st       <= ST_MEM_WAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_wait) begin
            st <= ST_RUN;
          end else if (wait_cnt == WAIT_W'(MEM_TIMEOUT)) begin
            st          <= ST_HALTED;
            mem_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ST_HALTED: st <= ST_HALTED;
        default:   st <= ST_RUN;
      endcase
    end
  end

  assign state = st;

  logic inc_load_use, inc_mispredict, inc_ret, inc_mem_wait;

  assign inc_load_use   = !halted && !mem_wait && load_use;
  assign inc_mispredict = !halted && !mem_wait && mispredict;
  assign inc_ret        = !halted && !mem_wait && !load_use && ret_p;
  assign inc_mem_wait   = !halted && mem_wait;

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_load_use (
    .clk(clk), .rst_n(rst_n), .inc(inc_load_use), .clr(cnt_clr), .count(cnt_load_use)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mispredict (
    .clk(clk), .rst_n(rst_n), .inc(inc_mispredict), .clr(cnt_clr), .count(cnt_mispredict)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_ret (
    .clk(clk), .rst_n(rst_n), .inc(inc_ret), .clr(cnt_clr), .count(cnt_ret)
  );

  hazard_perf_cnt #(.CNT_W(CNT_W)) u_cnt_mem_wait (
    .clk(clk), .rst_n(rst_n), .inc(inc_mem_wait), .clr(cnt_clr), .count(cnt_mem_wait)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// tb/tb_hazard_ctrl_unit.sv - directed self-checking bench for hazard_ctrl_unit
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] D_icode, E_icode, M_icode;
  logic       e_cnd;
  logic [3:0] E_dstM, d_srcA, d_srcB;
  logic [3:0] m_stat, W_stat;
  logic       mem_req, mem_ready, cnt_clr;

  // Default-parameter instance
  logic        F_stall, D_stall, E_stall, M_stall, W_stall;
  logic        D_bubble, E_bubble, M_bubble, W_bubble, set_cc;
  logic [1:0]  state;
  logic        mem_timeout;
  logic [31:0] cnt_load_use, cnt_mispredict, cnt_ret, cnt_mem_wait;

  // Short-timeout, narrow-counter instance
  logic        F_stall_t, D_stall_t, E_stall_t, M_stall_t, W_stall_t;
  logic        D_bubble_t, E_bubble_t, M_bubble_t, W_bubble_t, set_cc_t;
  logic [1:0]  state_t;
  logic        mem_timeout_t;
  logic [3:0]  cnt_load_use_t, cnt_mispredict_t, cnt_ret_t, cnt_mem_wait_t;

  // {F,D,E,M,W stall, D,E,M,W bubble, set_cc}
  logic [9:0] ctl, ctl_t;
  assign ctl   = {F_stall, D_stall, E_stall, M_stall, W_stall,
                  D_bubble, E_bubble, M_bubble, W_bubble, set_cc};
  assign ctl_t = {F_stall_t, D_stall_t, E_stall_t, M_stall_t, W_stall_t,
                  D_bubble_t, E_bubble_t, M_bubble_t, W_bubble_t, set_cc_t};

  hazard_ctrl_unit dut (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .e_cnd(e_cnd),
    .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .F_stall(F_stall), .D_stall(D_stall), .E_stall(E_stall), .M_stall(M_stall), .W_stall(W_stall),
    .D_bubble(D_bubble), .E_bubble(E_bubble), .M_bubble(M_bubble), .W_bubble(W_bubble),
    .set_cc(set_cc), .state(state), .mem_timeout(mem_timeout),
    .cnt_load_use(cnt_load_use), .cnt_mispredict(cnt_mispredict),
    .cnt_ret(cnt_ret), .cnt_mem_wait(cnt_mem_wait)
  );

  hazard_ctrl_unit #(.CNT_W(4), .MEM_TIMEOUT(3)) dut_t (
    .clk(clk), .rst_n(rst_n),
    .D_icode(D_icode), .E_icode(E_icode), .M_icode(M_icode), .e_cnd(e_cnd),
    .E_dstM(E_dstM), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .m_stat(m_stat), .W_stat(W_stat),
    .mem_req(mem_req), .mem_ready(mem_ready), .cnt_clr(cnt_clr),
    .F_stall(F_stall_t), .D_stall(D_stall_t), .E_stall(E_stall_t), .M_stall(M_stall_t),
    .W_stall(W_stall_t), .D_bubble(D_bubble_t), .E_bubble(E_bubble_t), .M_bubble(M_bubble_t),
    .W_bubble(W_bubble_t), .set_cc(set_cc_t), .state(state_t), .mem_timeout(mem_timeout_t),
    .cnt_load_use(cnt_load_use_t), .cnt_mispredict(cnt_mispredict_t),
    .cnt_ret(cnt_ret_t), .cnt_mem_wait(cnt_mem_wait_t)
  );

  always #5 clk = ~clk;

  int total    = 0;
  int pass_cnt = 0;
  int fail_cnt = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    D_icode   = 4'd1;
    E_icode   = 4'd1;
    M_icode   = 4'd1;
    e_cnd     = 1'b1;
    E_dstM    = 4'd15;
    d_srcA    = 4'd15;
    d_srcB    = 4'd15;
    m_stat    = 4'd1;
    W_stat    = 4'd1;
    mem_req   = 1'b0;
    mem_ready = 1'b0;
    cnt_clr   = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #2;
    // Reset state and forced outputs
    chk("rst_state", state, 2'd0);
    chk("rst_ctl", ctl, 10'b00000_1110_0);
    chk("rst_timeout", mem_timeout, 1'b0);
    chk("rst_cnt_lu", cnt_load_use, 32'd0);
    chk("rst_cnt_mw", cnt_mem_wait, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    chk("run_idle_ctl", ctl, 10'b00000_0000_0);

    // Load-use on mrmovq
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1;
    chk("load_use_ctl", ctl, 10'b11000_0100_0);
    tick();
    // RNONE destination matching an RNONE source is not a hazard
    E_dstM = 4'd15; d_srcA = 4'd15;
    #1;
    chk("rnone_ctl", ctl, 10'b00000_0000_0);
    tick();
    chk("cnt_lu_1", cnt_load_use, 32'd1);

    // Mispredicted jump
    E_icode = 4'd7; e_cnd = 1'b0;
    #1;
    chk("mispredict_ctl", ctl, 10'b00000_1100_0);
    tick();
    chk("cnt_mp_1", cnt_mispredict, 32'd1);
    E_icode = 4'd1; e_cnd = 1'b1;

    // ret walking D -> E -> M
    D_icode = 4'd9;
    #1;
    chk("ret_D_ctl", ctl, 10'b10000_1000_0);
    tick();
    D_icode = 4'd1; E_icode = 4'd9;
    #1;
    chk("ret_E_ctl", ctl, 10'b10000_1000_0);
    tick();
    E_icode = 4'd1; M_icode = 4'd9;
    #1;
    chk("ret_M_ctl", ctl, 10'b10000_1000_0);
    tick();
    M_icode = 4'd1;
    chk("cnt_ret_3", cnt_ret, 32'd3);

    // ret in D with load-use in E: load-use wins D, no ret count
    D_icode = 4'd9; E_icode = 4'd11; E_dstM = 4'd3; d_srcB = 4'd3;
    #1;
    chk("ret_lu_ctl", ctl, 10'b11000_0100_0);
    tick();
    chk("cnt_ret_hold", cnt_ret, 32'd3);
    chk("cnt_lu_2", cnt_load_use, 32'd2);
    idle_inputs();

    // OPq sets condition codes
    E_icode = 4'd6;
    #1;
    chk("set_cc_ctl", ctl, 10'b00000_0000_1);

    // Four memory-wait cycles
    mem_req = 1'b1; mem_ready = 1'b0;
    #1;
    chk("memwait_ctl", ctl, 10'b11110_0001_0);
    tick();
    chk("memwait_st1", state, 2'd1);
    tick();
    tick();
    #1;
    chk("memwait_ctl4", ctl, 10'b11110_0001_0);
    tick();
    chk("memwait_st4", state, 2'd1);
    mem_ready = 1'b1;
    #1;
    chk("memdone_ctl", ctl, 10'b00000_0000_1);
    tick();
    chk("memdone_st", state, 2'd0);
    chk("cnt_mw_4", cnt_mem_wait, 32'd4);
    chk("t_halted_by_timeout", {state_t, mem_timeout_t}, 3'b10_1);
    mem_req = 1'b0; mem_ready = 1'b0;

    // Writeback exception
    W_stat = 4'd3;
    #1;
    chk("exc_w_ctl", ctl, 10'b00001_0010_0);
    tick();
    chk("exc_halt_st", state, 2'd2);
    chk("exc_no_timeout", mem_timeout, 1'b0);
    W_stat = 4'd1; E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    #1;
    chk("halted_ctl", ctl, 10'b11111_0000_0);
    tick();
    chk("halted_cnt_frozen", cnt_load_use, 32'd2);

    // Asynchronous reset out of HALTED
    rst_n = 1'b0;
    #1;
    chk("async_rst_st", state, 2'd0);
    chk("async_rst_cnt", cnt_load_use, 32'd0);
    chk("async_rst_t_to", mem_timeout_t, 1'b0);
    idle_inputs();
    #1;
    rst_n = 1'b1;
    tick();

    // Timeout with MEM_TIMEOUT=3: halts on edge ending wait cycle 4
    mem_req = 1'b1;
    tick();
    tick();
    tick();
    chk("to_st3", {state_t, mem_timeout_t}, 3'b01_0);
    tick();
    chk("to_st4", {state_t, mem_timeout_t}, 3'b10_1);
    chk("to_ctl", ctl_t, 10'b11111_0000_0);
    chk("to_cnt_mw", cnt_mem_wait_t, 4'd4);
    mem_req = 1'b0;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();

    // mem_ready on the timeout-compare cycle: back to RUN, no timeout
    mem_req = 1'b1;
    tick();
    tick();
    tick();
    mem_ready = 1'b1;
    tick();
    chk("ready_at_to", {state_t, mem_timeout_t}, 3'b00_0);
    mem_req = 1'b0; mem_ready = 1'b0;

    // Saturation (4-bit) and clear priority
    E_icode = 4'd5; E_dstM = 4'd3; d_srcA = 4'd3;
    for (int i = 0; i < 17; i++) tick();
    chk("sat_cnt_t", cnt_load_use_t, 4'd15);
    chk("nosat_cnt", cnt_load_use, 32'd17);
    cnt_clr = 1'b1;
    tick();
    chk("clr_prio_t", cnt_load_use_t, 4'd0);
    chk("clr_prio", cnt_load_use, 32'd0);
    cnt_clr = 1'b0;
    tick();
    chk("after_clr", cnt_load_use, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
